fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage of the 5-stage MIPS pipeline: owns the PC, drives a variable-latency instruction-memory handshake, and loads the IF/ID pipeline register.
- Upstream of the decode stage. Consumes the StallF/StallD outputs of the hazard unit and the branch/jump redirects resolved in D.
- Absorbs memory latency by inserting bubbles into D. Squashes wrong-path fetches after a redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] ignored (forced to 00).

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- StallF  in  1  hold PC / do not consume fetched instruction
- StallD  in  1  hold IF/ID register contents
- pcsrcD  in  1  branch taken in D (redirect to pcbranchD)
- jumpD  in  1  jump in D (redirect to pcjumpD); priority over pcsrcD
- pcbranchD  in  32  branch target
- pcjumpD  in  32  jump target
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address (= pcF), word aligned
- imem_ready  in  1  rdata valid this cycle; completes the request
- imem_rdata  in  32  fetched instruction
- instrD  out  32  IF/ID instruction (0 = bubble)
- pcplus4D  out  32  IF/ID PC+4
- validD  out  1  IF/ID holds a real instruction
- pcF  out  32  current fetch PC (debug / trace)

Behaviour:
- Reset (sync, highest priority): pcF=RESET_PC&~3, state=RUN, instrD=0, pcplus4D=0, validD=0, skid buffer cleared, pending target cleared. imem_req=0 while reset is high; imem_req=1 from the first cycle after reset deasserts. Reset mid-transaction abandons the outstanding request; a late imem_ready is ignored only in the reset cycle.
- All arithmetic is 32-bit, modulo 2^32. pcF+4 wraps 32'hFFFF_FFFC -> 0. Redirect targets have bits [1:0] forced to 00.
- Redirect event R = (jumpD | pcsrcD) & validD & !StallD. Target T = jumpD ? pcjumpD : pcbranchD.
- States:
  - RUN: imem_req=1, imem_addr=pcF, address held stable until imem_ready.
    - imem_ready & !StallF & !R: pcF<=pcF+4. IF/ID<= {imem_rdata, pcF+4, valid=1} if !StallD.
    - imem_ready & StallF & !R: save rdata and pcF+4 in the skid buffer -> HELD.
    - !imem_ready & !StallD & !R: IF/ID <= bubble (instr 0, valid 0).
    - R & imem_ready: discard rdata, pcF<=T, IF/ID<=bubble, stay RUN.
    - R & !imem_ready: latch T in pending, IF/ID<=bubble -> SQUASH.
  - HELD: imem_req=0.
    - R: discard skid, pcF<=T, IF/ID<=bubble -> RUN.
    - else if !StallF: pcF<=pcF+4, IF/ID<=skid (if !StallD) -> RUN.
  - SQUASH: imem_req=1, same address held.
    - On imem_ready: drop rdata, pcF<=pending -> RUN.
    - IF/ID loads bubbles while !StallD.
    - A second R while in SQUASH overwrites pending (latest redirect wins).
- StallD=1: IF/ID holds all three outputs unchanged regardless of other events. R is never acted on while StallD=1.
- Latency: with imem_ready tied high and no stalls, one instruction per cycle. The instruction at pcF appears on instrD the cycle after the address is presented.
- No instruction is ever lost or duplicated across any stall/redirect/latency combination.

Test Plan:
- Reset, RESET_PC=0x100, imem_ready=1, no stalls -> imem_addr 0x100,0x104,0x108 on consecutive cycles; instrD follows one cycle later with validD=1, pcplus4D=0x104,0x108,...
- imem_ready low 3 cycles at addr 0x200 -> imem_addr held at 0x200, validD=0 for 3 cycles, then instrD=rdata(0x200), pcplus4D=0x204.
- StallF=StallD=1 for 2 cycles while the response to 0x300 arrives -> state HELD, imem_req=0, IF/ID unchanged. After release, instrD=rdata(0x300), next addr 0x304.
- jumpD=1 with pcjumpD=0x403, request outstanding 2 more cycles -> SQUASH. Stale rdata dropped, next imem_addr=0x400, validD=0 until 0x400 instruction arrives.
- pcsrcD=1 and jumpD=1 in the same cycle -> target is pcjumpD. pcsrcD=1 with StallD=1 -> no redirect until StallD drops.
- pcF=0xFFFF_FFFC, ready=1 -> next imem_addr=0x0000_0000, pcplus4D=0. Reset asserted in SQUASH -> pcF=RESET_PC, validD=0, pending discarded.

Source files
------------

// File: rtl/fetch_stage.sv
// IF stage: owns the PC and runs the variable-latency instruction-memory handshake.
// It loads IF/ID and uses a one-entry skid buffer plus a pending redirect target.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        pcsrcD,
  input  logic        jumpD,
  input  logic [31:0] pcbranchD,
  input  logic [31:0] pcjumpD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrD,
  output logic [31:0] pcplus4D,
  output logic        validD,
  output logic [31:0] pcF
);

  typedef enum logic [1:0] {StRun, StHeld, StSquash} state_e;

  state_e      state_q;
  logic [31:0] pc_q, pend_q, skid_instr_q, skid_pc4_q;
  logic [31:0] instr_q, pc4_q;
  logic        valid_q;

  logic        redirect;
  logic [31:0] target, pc_plus4;

  always_comb begin
    redirect = (jumpD | pcsrcD) & valid_q & ~StallD;
    target   = (jumpD ? pcjumpD : pcbranchD) & 32'hFFFF_FFFC;
    pc_plus4 = pc_q + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StRun;
      pc_q         <= RESET_PC & 32'hFFFF_FFFC;
      pend_q       <= '0;
      skid_instr_q <= '0;
      skid_pc4_q   <= '0;
      instr_q      <= '0;
      pc4_q        <= '0;
      valid_q      <= 1'b0;
    end else begin
      // IF/ID takes a bubble unless a real instruction is delivered below.
      if (!StallD) begin
        instr_q <= '0;
        pc4_q   <= '0;
        valid_q <= 1'b0;
      end
      unique case (state_q)
        StRun: begin
          if (redirect) begin
            if (imem_ready) begin
              pc_q <= target;
            end else begin
              pend_q  <= target;
              state_q <= StSquash;
            end
          end else if (imem_ready) begin
            if (!StallF) begin
              pc_q <= pc_plus4;
              if (!StallD) begin
                instr_q <= imem_rdata;
                pc4_q   <= pc_plus4;
                valid_q <= 1'b1;
              end
            end else begin
              skid_instr_q <= imem_rdata;
              skid_pc4_q   <= pc_plus4;
              state_q      <= StHeld;
            end
          end
        end
        StHeld: begin
          if (redirect) begin
            pc_q    <= target;
            state_q <= StRun;
          end else if (!StallF) begin
            pc_q    <= pc_plus4;
            state_q <= StRun;
            if (!StallD) begin
              instr_q <= skid_instr_q;
              pc4_q   <= skid_pc4_q;
              valid_q <= 1'b1;
            end
          end
        end
        StSquash: begin
          // Wrong-path response is dropped; the latest redirect wins.
          if (imem_ready) begin
            pc_q    <= redirect ? target : pend_q;
            state_q <= StRun;
          end else if (redirect) begin
            pend_q <= target;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  always_comb begin
    imem_req  = ~reset & (state_q != StHeld);
    imem_addr = pc_q;
    pcF       = pc_q;
    instrD    = instr_q;
    pcplus4D  = pc4_q;
    validD    = valid_q;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage; memory returns {8'hAB, addr[23:0]}.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, StallF, StallD, pcsrcD, jumpD, imem_ready;
  logic [31:0] pcbranchD, pcjumpD, imem_rdata;
  logic        imem_req, validD;
  logic [31:0] imem_addr, instrD, pcplus4D, pcF;

  int total = 0;
  int bad   = 0;
  bit done  = 1'b0;

  always #5 clk = ~clk;

  assign imem_rdata = {8'hAB, imem_addr[23:0]};

  fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
    .clk        (clk),
    .reset      (reset),
    .StallF     (StallF),
    .StallD     (StallD),
    .pcsrcD     (pcsrcD),
    .jumpD      (jumpD),
    .pcbranchD  (pcbranchD),
    .pcjumpD    (pcjumpD),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .instrD     (instrD),
    .pcplus4D   (pcplus4D),
    .validD     (validD),
    .pcF        (pcF)
  );

  typedef struct {
    logic        rst, sf, sd, br, jp, rdy;
    logic [31:0] tb, tj;
    logic        e_req, e_valid;
    logic [31:0] e_addr, e_instr, e_p4;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic sf, input logic sd, input logic br,
                     input logic jp, input logic [31:0] tb, input logic [31:0] tj,
                     input logic rdy, input logic e_req, input logic [31:0] e_addr,
                     input logic e_valid, input logic [31:0] e_instr,
                     input logic [31:0] e_p4);
    vec_t v;
    v.rst = rst; v.sf = sf; v.sd = sd; v.br = br; v.jp = jp; v.tb = tb; v.tj = tj;
    v.rdy = rdy; v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_instr = e_instr; v.e_p4 = e_p4;
    vecs.push_back(v);
  endtask

  initial begin
    repeat (400) @(posedge clk);
    if (!done) begin
      bad++;
      $display("FAIL timeout: vector run did not finish within 400 cycles");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    reset = 1'b1; StallF = 0; StallD = 0; pcsrcD = 0; jumpD = 0;
    pcbranchD = '0; pcjumpD = '0; imem_ready = 1'b1;

    //  rst sf sd br jp  tb          tj          rdy req addr        v  instr       p4
    add(1, 0, 0, 0, 0, 0,          0,          1,  0, 32'h100,      0, 0,           0);
    add(0, 0, 0, 0, 0, 0,          0,          1,  1, 32'h100,      0, 0,           0);
    add(0, 0, 0, 0, 0, 0,          0,          1,  1, 32'h104,      1, 32'hAB000100, 32'h104);
    add(0, 0, 0, 0, 0, 0,          0,          1,  1, 32'h108,      1, 32'hAB000104, 32'h108);
    add(0, 0, 0, 0, 1, 0,          32'h200,    1,  1, 32'h10C,      1, 32'hAB000108, 32'h10C);
    add(0, 0, 0, 0, 0, 0,          0,          0,  1, 32'h200,      0, 0,           0);
    add(0, 0, 0, 0, 0, 0,          0,          0,  1, 32'h200,      0, 0,           0);
    add(0, 0, 0, 0, 0, 0,          0,          0,  1, 32'h200,      0, 0,           0);
    add(0, 0, 0, 0, 0, 0,          0,          1,  1, 32'h200,      0, 0,           0);
    add(0, 0, 0, 0, 0, 0,          0,          1,  1, 32'h204,      1, 32'hAB000200, 32'h204);
    add(0, 0, 0, 0, 1, 0,          32'h2F8,    1,  1, 32'h208,      1, 32'hAB000204, 32'h208);
    add(0, 0, 0, 0, 0, 0,          0,          1,  1, 32'h2F8,      0, 0,           0);
    add(0, 0, 0, 0, 0, 0,          0,          1,  1, 32'h2FC,      1, 32'hAB0002F8, 32'h2FC);
    // response to 0x300 arrives under StallF/StallD -> skid
    add(0, 1, 1, 0, 0, 0,          0,          1,  1, 32'h300,      1, 32'hAB0002FC, 32'h300);
    add(0, 1, 1, 0, 0, 0,          0,          1,  0, 32'h300,      1, 32'hAB0002FC, 32'h300);
    add(0, 0, 0, 0, 0, 0,          0,          1,  0, 32'h300,      1, 32'hAB0002FC, 32'h300);
    // jump to 0x403 while request to 0x304 is outstanding -> squash
    add(0, 0, 0, 0, 1, 0,          32'h403,    0,  1, 32'h304,      1, 32'hAB000300, 32'h304);
    add(0, 0, 0, 0, 0, 0,          0,          0,  1, 32'h304,      0, 0,           0);
    add(0, 0, 0, 0, 0, 0,          0,          1,  1, 32'h304,      0, 0,           0);
    add(0, 0, 0, 0, 0, 0,          0,          1,  1, 32'h400,      0, 0,           0);
    // jump has priority over branch
    add(0, 0, 0, 1, 1, 32'h600,    32'h500,    1,  1, 32'h404,      1, 32'hAB000400, 32'h404);
    add(0, 0, 0, 0, 0, 0,          0,          1,  1, 32'h500,      0, 0,           0);
    // branch under StallD is deferred until StallD drops
    add(0, 1, 1, 1, 0, 32'h700,    0,          1,  1, 32'h504,      1, 32'hAB000500, 32'h504);
    add(0, 0, 0, 1, 0, 32'h700,    0,          1,  0, 32'h504,      1, 32'hAB000500, 32'h504);
    add(0, 0, 0, 0, 0, 0,          0,          1,  1, 32'h700,      0, 0,           0);
    // low target bits forced to zero, then PC wraps
    add(0, 0, 0, 0, 1, 0,          32'hFFFFFFFF, 1, 1, 32'h704,     1, 32'hAB000700, 32'h704);
    add(0, 0, 0, 0, 0, 0,          0,          1,  1, 32'hFFFFFFFC, 0, 0,           0);
    add(0, 0, 0, 0, 0, 0,          0,          1,  1, 32'h0,        1, 32'hABFFFFFC, 32'h0);
    // reset while squashing; late ready in the reset cycle ignored
    add(0, 0, 0, 0, 1, 0,          32'h800,    0,  1, 32'h4,        1, 32'hAB000000, 32'h4);
    add(1, 0, 0, 0, 0, 0,          0,          1,  0, 32'h4,        0, 0,           0);
    add(0, 0, 0, 0, 0, 0,          0,          1,  1, 32'h100,      0, 0,           0);
    add(0, 0, 0, 0, 0, 0,          0,          1,  1, 32'h104,      1, 32'hAB000100, 32'h104);

    @(posedge clk);
    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; StallF = vecs[i].sf; StallD = vecs[i].sd;
      pcsrcD = vecs[i].br; jumpD = vecs[i].jp; pcbranchD = vecs[i].tb;
      pcjumpD = vecs[i].tj; imem_ready = vecs[i].rdy;
      #1;
      total++;
      if ({imem_req, imem_addr, validD, instrD, pcplus4D} !==
          {vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_p4}) begin
        bad++;
        $display("FAIL vec%0d: got req=%b addr=%h v=%b instr=%h p4=%h want req=%b addr=%h v=%b instr=%h p4=%h",
                 i, imem_req, imem_addr, validD, instrD, pcplus4D, vecs[i].e_req,
                 vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_p4);
      end
      if (i > 0 && vecs[i-1].rst) begin
        total++;
        if ({pcF, validD, instrD, pcplus4D} !== {32'h0000_0100, 1'b0, 32'h0, 32'h0}) begin
          bad++;
          $display("FAIL reset state vec%0d: pcF=%h v=%b instr=%h p4=%h", i, pcF, validD,
                   instrD, pcplus4D);
        end
      end
    end

    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
